// File: rtl/cmp_sched.sv
// cmp_sched: two-requester round-robin scheduler that compares WIDTH-bit
// operands one nibble per cycle through a single shared 4-bit cascadable
// comparator slice, LSB nibble first.

module cmp_sched #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic             req1,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             busy,
   output logic             done,
   output logic             done_id,
   output logic             lt,
   output logic             eq,
   output logic             gr
);

   localparam int SLICES = WIDTH / 4;
   localparam int CW     = (SLICES > 1) ? $clog2(SLICES) : 1;
   localparam logic [CW-1:0] LAST_SLICE = CW'(SLICES - 1);

   // Operand width must split evenly into nibbles for the shared slice
   if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_width_check
      $error("cmp_sched: WIDTH must be a multiple of 4 and at least 4");
   end

   typedef enum logic [1:0] {
      IDLE,
      CMP,
      DONE
   } state_t;

   state_t state;
   state_t next_state;

   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [CW-1:0]    slice_cnt;
   logic             cas_lt;
   logic             cas_eq;
   logic             cas_gr;
   logic             last_served;
   logic             cur_id;

   logic             accept;
   logic             winner;
   logic             last_slice;

   logic [3:0]       slice_a;
   logic [3:0]       slice_b;
   logic             slice_lt;
   logic             slice_eq;
   logic             slice_gr;

   // State register; reset drops straight back to IDLE, aborting any operation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Arbitration and next state: requests only matter in IDLE, ties go to the requester not served last
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      winner     = 1'b0;
      last_slice = (slice_cnt == LAST_SLICE);
      unique case (state)
         IDLE: begin
            accept = req0 | req1;
            if (req0 && req1) begin
               winner = ~last_served;
            end else begin
               winner = req1;
            end
            if (accept) begin
               next_state = CMP;
            end
         end
         CMP: begin
            if (last_slice) begin
               next_state = DONE;
            end
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Pick the nibble pair for the current slice index out of the latched operands
   always_comb begin
      slice_a = a_reg[3:0];
      slice_b = b_reg[3:0];
      for (int k = 0; k < SLICES; k++) begin
         if (slice_cnt == CW'(k)) begin
            slice_a = a_reg[4*k +: 4];
            slice_b = b_reg[4*k +: 4];
         end
      end
   end

   // The one comparator slice; its cascade inputs come from the previous cycle's verdict
   cmp_slice4 u_slice (
      .A    (slice_a),
      .B    (slice_b),
      .GR_I (cas_gr),
      .EQ_I (cas_eq),
      .LT_I (cas_lt),
      .LT   (slice_lt),
      .EQ   (slice_eq),
      .GR   (slice_gr)
   );

   // Accept latches operands and seeds the cascade as "equal so far"; each CMP edge walks one slice up
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg       <= '0;
         b_reg       <= '0;
         slice_cnt   <= '0;
         cas_lt      <= 1'b0;
         cas_eq      <= 1'b0;
         cas_gr      <= 1'b0;
         cur_id      <= 1'b0;
         last_served <= 1'b1;
         gnt0        <= 1'b0;
         gnt1        <= 1'b0;
      end else begin
         gnt0 <= accept & ~winner;
         gnt1 <= accept & winner;
         if (accept) begin
            a_reg       <= winner ? a1 : a0;
            b_reg       <= winner ? b1 : b0;
            slice_cnt   <= '0;
            cas_lt      <= 1'b0;
            cas_eq      <= 1'b1;
            cas_gr      <= 1'b0;
            cur_id      <= winner;
            last_served <= winner;
         end else if (state == CMP) begin
            slice_cnt <= slice_cnt + 1'b1;
            cas_lt    <= slice_lt;
            cas_eq    <= slice_eq;
            cas_gr    <= slice_gr;
         end
      end
   end

   // Result registers load only on the final slice and then hold until the next completion
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done    <= 1'b0;
         done_id <= 1'b0;
         lt      <= 1'b0;
         eq      <= 1'b0;
         gr      <= 1'b0;
      end else begin
         done <= 1'b0;
         if ((state == CMP) && last_slice) begin
            done    <= 1'b1;
            done_id <= cur_id;
            lt      <= slice_lt;
            eq      <= slice_eq;
            gr      <= slice_gr;
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// cmp_slice4: 4-bit cascadable magnitude comparator. A differing nibble
// decides on its own; an equal nibble passes the lower-order verdict through.

module cmp_slice4 (
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic       GR_I,
   input  logic       EQ_I,
   input  logic       LT_I,
   output logic       LT,
   output logic       EQ,
   output logic       GR
);

   // Higher-order slice overrides the cascade whenever its nibbles differ
   always_comb begin
      LT = 1'b0;
      EQ = 1'b0;
      GR = 1'b0;
      if (A > B) begin
         GR = 1'b1;
      end else if (A < B) begin
         LT = 1'b1;
      end else begin
         LT = LT_I;
         EQ = EQ_I;
         GR = GR_I;
      end
   end

endmodule

// File: tb/tb_cmp_sched.sv
// tb_cmp_sched: self-checking bench for cmp_sched with a 16-bit and a 4-bit
// instance, compared against an arithmetic reference model of arbitration,
// latency and comparison result.

module tb_cmp_sched;

   localparam int W  = 16;
   localparam int SL = W / 4;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        req0, req1;
   logic [15:0] a0, b0, a1, b1;
   logic        gnt0, gnt1, busy, done, done_id, lt, eq, gr;

   logic        n_req0, n_req1;
   logic [3:0]  n_a0, n_b0, n_a1, n_b1;
   logic        n_gnt0, n_gnt1, n_busy, n_done, n_done_id, n_lt, n_eq, n_gr;

   int          checks = 0;
   int          errors = 0;
   bit          model_last;
   bit          model_last4;
   bit          last_id;
   logic [2:0]  last_res;

   typedef struct {
      int         gnt_cyc;
      bit         gnt_id;
      int         gnt_width;
      bit         both;
      bit         busy_at_gnt;
      int         done_cyc;
      int         done_width;
      bit         res_id;
      logic [2:0] res;
   } obs_t;

   cmp_sched #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req0    (req0),
      .a0      (a0),
      .b0      (b0),
      .req1    (req1),
      .a1      (a1),
      .b1      (b1),
      .gnt0    (gnt0),
      .gnt1    (gnt1),
      .busy    (busy),
      .done    (done),
      .done_id (done_id),
      .lt      (lt),
      .eq      (eq),
      .gr      (gr)
   );

   cmp_sched #(.WIDTH(4)) dut4 (
      .clk     (clk),
      .rst_n   (rst_n),
      .req0    (n_req0),
      .a0      (n_a0),
      .b0      (n_b0),
      .req1    (n_req1),
      .a1      (n_a1),
      .b1      (n_b1),
      .gnt0    (n_gnt0),
      .gnt1    (n_gnt1),
      .busy    (n_busy),
      .done    (n_done),
      .done_id (n_done_id),
      .lt      (n_lt),
      .eq      (n_eq),
      .gr      (n_gr)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Reference result: {lt, eq, gr} straight from unsigned arithmetic
   function automatic logic [2:0] model_cmp(input logic [15:0] x, input logic [15:0] y);
      return {x < y, x == y, x > y};
   endfunction

   // Reference arbitration: lone request wins, a tie goes to the one not served last
   function automatic bit model_winner(input bit r0, input bit r1, input bit last);
      if (r0 && r1) return ~last;
      return r1;
   endfunction

   // Issue one request pattern to the chosen instance and record what it does
   task automatic run_op(input bit narrow, input bit r0, input bit r1,
                         input logic [15:0] x0, input logic [15:0] y0,
                         input logic [15:0] x1, input logic [15:0] y1,
                         output obs_t o);
      bit g0, g1, d, bz;
      o.gnt_cyc = -1; o.gnt_id = 0; o.gnt_width = 0; o.both = 0; o.busy_at_gnt = 0;
      o.done_cyc = -1; o.done_width = 0; o.res_id = 0; o.res = 3'bxxx;
      if (narrow) begin
         n_req0 = r0; n_req1 = r1;
         n_a0 = x0[3:0]; n_b0 = y0[3:0]; n_a1 = x1[3:0]; n_b1 = y1[3:0];
      end else begin
         req0 = r0; req1 = r1; a0 = x0; b0 = y0; a1 = x1; b1 = y1;
      end
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         g0 = narrow ? n_gnt0 : gnt0;
         g1 = narrow ? n_gnt1 : gnt1;
         d  = narrow ? n_done : done;
         bz = narrow ? n_busy : busy;
         if (g0 && g1) o.both = 1;
         if (g0 || g1) begin
            if (o.gnt_cyc < 0) begin
               o.gnt_cyc = c; o.gnt_id = g1; o.busy_at_gnt = bz;
            end
            o.gnt_width++;
            req0 = 0; req1 = 0; n_req0 = 0; n_req1 = 0;
         end
         if (d) begin
            if (o.done_cyc < 0) begin
               o.done_cyc = c;
               o.res_id = narrow ? n_done_id : done_id;
               o.res = narrow ? {n_lt, n_eq, n_gr} : {lt, eq, gr};
            end
            o.done_width++;
         end
         if ((o.done_cyc >= 0) && (c >= o.done_cyc + 2)) break;
      end
      req0 = 0; req1 = 0; n_req0 = 0; n_req1 = 0;
   endtask

   // Everything low while reset is held
   task automatic test_reset;
      logic [7:0] obs;
      string names [8] = '{"gnt0", "gnt1", "busy", "done", "done_id", "lt", "eq", "gr"};
      rst_n = 0;
      req0 = 0; req1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
      n_req0 = 0; n_req1 = 0; n_a0 = 0; n_b0 = 0; n_a1 = 0; n_b1 = 0;
      repeat (2) @(negedge clk);
      obs = {gnt0, gnt1, busy, done, done_id, lt, eq, gr};
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (obs[7-i] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_%s: got %b expected 0", names[i], obs[7-i]);
         end
      end
      rst_n = 1;
      model_last = 1; model_last4 = 1;
   endtask

   // Equal operands from requester 0
   task automatic test_eq;
      obs_t o; bit e_id; logic [2:0] e_res;
      run_op(0, 1, 0, 16'h1234, 16'h1234, 16'h0, 16'h0, o);
      e_id = model_winner(1, 0, model_last);
      e_res = model_cmp(16'h1234, 16'h1234);
      checks++;
      if ((o.gnt_cyc !== 1) || (o.gnt_width !== 1) || o.both || !o.busy_at_gnt ||
          ((o.done_cyc - o.gnt_cyc) !== SL) || (o.done_width !== 1)) begin
         errors++;
         $display("[TB] FAIL eq_timing: got gnt_cyc=%0d gnt_w=%0d both=%0b busy=%0b done_delta=%0d done_w=%0d expected 1 1 0 1 %0d 1",
                  o.gnt_cyc, o.gnt_width, o.both, o.busy_at_gnt, o.done_cyc - o.gnt_cyc, o.done_width, SL);
      end
      checks++;
      if ({o.gnt_id, o.res_id} !== {e_id, e_id}) begin
         errors++;
         $display("[TB] FAIL eq_id: got gnt_id=%0b done_id=%0b expected %0b", o.gnt_id, o.res_id, e_id);
      end
      checks++;
      if (o.res !== e_res) begin
         errors++;
         $display("[TB] FAIL eq_result: got lt/eq/gr=%b expected %b", o.res, e_res);
      end
      model_last = e_id; last_id = e_id; last_res = e_res;
   endtask

   // MSB slice overrides a lower-slice "less than"
   task automatic test_gr_msb;
      obs_t o; bit e_id; logic [2:0] e_res;
      run_op(0, 0, 1, 16'h0, 16'h0, 16'h8000, 16'h7FFF, o);
      e_id = model_winner(0, 1, model_last);
      e_res = model_cmp(16'h8000, 16'h7FFF);
      checks++;
      if ((o.gnt_cyc !== 1) || (o.gnt_width !== 1) || o.both ||
          ((o.done_cyc - o.gnt_cyc) !== SL) || (o.done_width !== 1)) begin
         errors++;
         $display("[TB] FAIL gr_timing: got gnt_cyc=%0d gnt_w=%0d both=%0b done_delta=%0d done_w=%0d expected 1 1 0 %0d 1",
                  o.gnt_cyc, o.gnt_width, o.both, o.done_cyc - o.gnt_cyc, o.done_width, SL);
      end
      checks++;
      if ({o.gnt_id, o.res_id} !== {e_id, e_id}) begin
         errors++;
         $display("[TB] FAIL gr_id: got gnt_id=%0b done_id=%0b expected %0b", o.gnt_id, o.res_id, e_id);
      end
      checks++;
      if (o.res !== e_res) begin
         errors++;
         $display("[TB] FAIL gr_result: got lt/eq/gr=%b expected %b", o.res, e_res);
      end
      model_last = e_id; last_id = e_id; last_res = e_res;
   endtask

   // Only the LSB slice differs; equal upper slices must pass it through
   task automatic test_lt_lsb;
      obs_t o; bit e_id; logic [2:0] e_res;
      run_op(0, 1, 0, 16'h00F0, 16'h00F1, 16'h0, 16'h0, o);
      e_id = model_winner(1, 0, model_last);
      e_res = model_cmp(16'h00F0, 16'h00F1);
      checks++;
      if ((o.gnt_cyc !== 1) || (o.gnt_width !== 1) || ((o.done_cyc - o.gnt_cyc) !== SL)) begin
         errors++;
         $display("[TB] FAIL lt_timing: got gnt_cyc=%0d gnt_w=%0d done_delta=%0d expected 1 1 %0d",
                  o.gnt_cyc, o.gnt_width, o.done_cyc - o.gnt_cyc, SL);
      end
      checks++;
      if ({o.gnt_id, o.res_id} !== {e_id, e_id}) begin
         errors++;
         $display("[TB] FAIL lt_id: got gnt_id=%0b done_id=%0b expected %0b", o.gnt_id, o.res_id, e_id);
      end
      checks++;
      if (o.res !== e_res) begin
         errors++;
         $display("[TB] FAIL lt_result: got lt/eq/gr=%b expected %b", o.res, e_res);
      end
      model_last = e_id; last_id = e_id; last_res = e_res;
   endtask

   // Results stay put while idle and no stray done/busy appears
   task automatic test_hold;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if ({done_id, lt, eq, gr, done, busy} !== {last_id, last_res, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL hold: got id/lt/eq/gr/done/busy=%b expected %b",
                     {done_id, lt, eq, gr, done, busy}, {last_id, last_res, 2'b00});
         end
      end
   endtask

   // Both requests held from reset: alternate grants, fixed spacing
   task automatic test_round_robin;
      int g_cyc [$];
      bit g_id [$];
      bit d_id [$];
      bit e_id;
      @(negedge clk);
      rst_n = 0;
      req0 = 1; req1 = 1;
      a0 = 16'($urandom); b0 = 16'($urandom); a1 = 16'($urandom); b1 = 16'($urandom);
      @(negedge clk);
      rst_n = 1;
      model_last = 1; model_last4 = 1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (gnt0 || gnt1) begin
            g_cyc.push_back(c);
            g_id.push_back(gnt1);
            if (g_cyc.size() == 3) begin
               req0 = 0; req1 = 0;
            end
         end
         if (done) d_id.push_back(done_id);
         if ((d_id.size() == 3) && !busy) break;
      end
      req0 = 0; req1 = 0;
      checks++;
      if ((g_cyc.size() != 3) || (d_id.size() != 3)) begin
         errors++;
         $display("[TB] FAIL rr_count: got %0d grants %0d dones expected 3 3", g_cyc.size(), d_id.size());
      end else begin
         checks++;
         if (g_cyc[0] !== 1) begin
            errors++;
            $display("[TB] FAIL rr_first_accept: got cycle %0d expected 1", g_cyc[0]);
         end
         for (int i = 0; i < 3; i++) begin
            e_id = model_winner(1, 1, model_last);
            model_last = e_id;
            checks++;
            if ((g_id[i] !== e_id) || (d_id[i] !== e_id)) begin
               errors++;
               $display("[TB] FAIL rr_order_%0d: got gnt_id=%0b done_id=%0b expected %0b", i, g_id[i], d_id[i], e_id);
            end
            if (i > 0) begin
               checks++;
               if ((g_cyc[i] - g_cyc[i-1]) !== (SL + 2)) begin
                  errors++;
                  $display("[TB] FAIL rr_spacing_%0d: got %0d expected %0d", i, g_cyc[i] - g_cyc[i-1], SL + 2);
               end
            end
         end
      end
   endtask

   // Reset two cycles into an operation aborts it silently
   task automatic test_reset_abort;
      bit seen = 0;
      req0 = 1; a0 = 16'h00F0; b0 = 16'h0F00;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (gnt0) begin
            seen = 1;
            break;
         end
      end
      req0 = 0;
      checks++;
      if (!seen) begin
         errors++;
         $display("[TB] FAIL abort_grant: got no gnt0 within 10 cycles expected gnt0");
      end
      repeat (2) @(negedge clk);
      rst_n = 0;
      #1;
      checks++;
      if ({busy, done, lt, eq, gr, gnt0, gnt1} !== 7'b0) begin
         errors++;
         $display("[TB] FAIL abort_outputs: got busy/done/lt/eq/gr/gnt0/gnt1=%b expected 0000000",
                  {busy, done, lt, eq, gr, gnt0, gnt1});
      end
      @(negedge clk);
      rst_n = 1;
      model_last = 1; model_last4 = 1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         checks++;
         if ((done !== 1'b0) || (busy !== 1'b0)) begin
            errors++;
            $display("[TB] FAIL abort_quiet: got done=%b busy=%b expected 0 0", done, busy);
         end
      end
   endtask

   // Random request patterns and operands against the model
   task automatic test_random;
      obs_t o; bit e_id; logic [2:0] e_res;
      bit r0, r1;
      logic [15:0] x0, y0, x1, y1, ex, ey;
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 2))
            0: begin r0 = 1; r1 = 0; end
            1: begin r0 = 0; r1 = 1; end
            default: begin r0 = 1; r1 = 1; end
         endcase
         x0 = 16'($urandom); x1 = 16'($urandom);
         case ($urandom_range(0, 3))
            0: begin y0 = 16'($urandom); y1 = 16'($urandom); end
            1: begin y0 = x0; y1 = x1; end
            2: begin y0 = x0 ^ (16'h1 << $urandom_range(0, 15)); y1 = x1 ^ (16'h1 << $urandom_range(0, 15)); end
            default: begin y0 = {x0[15:4], 4'($urandom)}; y1 = {x1[15:4], 4'($urandom)}; end
         endcase
         run_op(0, r0, r1, x0, y0, x1, y1, o);
         e_id = model_winner(r0, r1, model_last);
         ex = e_id ? x1 : x0;
         ey = e_id ? y1 : y0;
         e_res = model_cmp(ex, ey);
         checks++;
         if ((o.gnt_cyc !== 1) || (o.gnt_width !== 1) || o.both ||
             ((o.done_cyc - o.gnt_cyc) !== SL) || (o.done_width !== 1)) begin
            errors++;
            $display("[TB] FAIL rand_timing_%0d: got gnt_cyc=%0d gnt_w=%0d both=%0b done_delta=%0d done_w=%0d expected 1 1 0 %0d 1",
                     n, o.gnt_cyc, o.gnt_width, o.both, o.done_cyc - o.gnt_cyc, o.done_width, SL);
         end
         checks++;
         if ({o.gnt_id, o.res_id, o.res} !== {e_id, e_id, e_res}) begin
            errors++;
            $display("[TB] FAIL rand_result_%0d: got gnt_id=%0b done_id=%0b lt/eq/gr=%b expected %0b %0b %b (a=%h b=%h)",
                     n, o.gnt_id, o.res_id, o.res, e_id, e_id, e_res, ex, ey);
         end
         model_last = e_id;
      end
   endtask

   // 4-bit instance: a single slice, so done follows gnt by one cycle
   task automatic test_width4;
      obs_t o; bit e_id; logic [2:0] e_res;
      logic [15:0] x, y;
      for (int n = 0; n < 9; n++) begin
         if (n == 0) begin
            x = 16'h9; y = 16'h3;
         end else begin
            x = 16'($urandom_range(0, 15));
            y = (n % 3 == 0) ? x : 16'($urandom_range(0, 15));
         end
         run_op(1, 1, 0, x, y, 16'h0, 16'h0, o);
         e_id = model_winner(1, 0, model_last4);
         e_res = model_cmp(x, y);
         checks++;
         if ((o.gnt_cyc !== 1) || (o.gnt_width !== 1) || ((o.done_cyc - o.gnt_cyc) !== 1) || (o.done_width !== 1)) begin
            errors++;
            $display("[TB] FAIL w4_timing_%0d: got gnt_cyc=%0d gnt_w=%0d done_delta=%0d done_w=%0d expected 1 1 1 1",
                     n, o.gnt_cyc, o.gnt_width, o.done_cyc - o.gnt_cyc, o.done_width);
         end
         checks++;
         if ({o.gnt_id, o.res_id, o.res} !== {e_id, e_id, e_res}) begin
            errors++;
            $display("[TB] FAIL w4_result_%0d: got gnt_id=%0b done_id=%0b lt/eq/gr=%b expected %0b %0b %b",
                     n, o.gnt_id, o.res_id, o.res, e_id, e_id, e_res);
         end
         model_last4 = e_id;
      end
   endtask

   // Scenario sequence
   initial begin
      test_reset();
      test_eq();
      test_gr_msb();
      test_lt_lsb();
      test_hold();
      test_round_robin();
      test_reset_abort();
      test_random();
      test_width4();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Runaway guard
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
